// File: rtl/rv32_bus_arbiter.sv
// rv32_bus_arbiter
// ----------------
// Shares one memory bus between an instruction-fetch requester and a data
// requester. When both ask in the same cycle, the grant alternates between
// them. A granted access either completes when the slave raises
// bus_ready_in, times out after TIMEOUT_CYCLES bus cycles with a fault
// pulse, or is abandoned when the requester drops its request. Requester
// address and data pass straight through to the bus and are never stored.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   instr_address_in/read_in    fetch request
//   instr_read_value_out        fetched word, valid while instr_ready_out is high
//   instr_ready_out/fault_out   fetch completion / timeout
//   data_address_in             data address
//   data_read_in/write_in       data request (write wins when both are high)
//   data_write_mask_in/value_in byte enables and store data
//   data_read_value_out         load data, valid while data_ready_out is high
//   data_ready_out/fault_out    data completion / timeout
//   bus_*_out                   bus master side
//   bus_read_value_in           slave read data
//   bus_ready_in                slave completes the current access this cycle
//   busy_out                    arbiter is holding a grant
module rv32_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_address_in,
  input  logic        instr_read_in,
  output logic [31:0] instr_read_value_out,
  output logic        instr_ready_out,
  output logic        instr_fault_out,
  input  logic [31:0] data_address_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_write_value_in,
  output logic [31:0] data_read_value_out,
  output logic        data_ready_out,
  output logic        data_fault_out,
  output logic [31:0] bus_address_out,
  output logic        bus_read_out,
  output logic        bus_write_out,
  output logic [3:0]  bus_write_mask_out,
  output logic [31:0] bus_write_value_out,
  input  logic [31:0] bus_read_value_in,
  input  logic        bus_ready_in,
  output logic        busy_out
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_INSTR,
    GRANT_DATA
  } state_t;

  // The count is cleared on grant entry, so during grant cycle k it holds k-1.
  // The last permitted cycle is therefore the one where it equals TIMEOUT_CYCLES-1.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, state_next;
  logic       last_grant, last_grant_next;   // 1 = data was granted last
  logic [7:0] count, count_next;

  logic instr_req;
  logic data_req;
  logic timed_out;

  assign instr_req = instr_read_in;
  assign data_req  = data_read_in | data_write_in;
  assign timed_out = (count == TIMEOUT_LAST) && !bus_ready_in;

  // Read data only matters while ready is high, so both requesters see the
  // slave data directly.
  assign instr_read_value_out = bus_read_value_in;
  assign data_read_value_out  = bus_read_value_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      count      <= 8'd0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      count      <= count_next;
    end
  end

  // Next-state and bus steering. Inside a grant the priority is:
  // request dropped (abort) > slave ready > timeout > keep waiting.
  always_comb begin
    state_next          = state;
    last_grant_next     = last_grant;
    count_next          = count;
    instr_ready_out     = 1'b0;
    instr_fault_out     = 1'b0;
    data_ready_out      = 1'b0;
    data_fault_out      = 1'b0;
    bus_address_out     = 32'd0;
    bus_read_out        = 1'b0;
    bus_write_out       = 1'b0;
    bus_write_mask_out  = 4'd0;
    bus_write_value_out = 32'd0;
    busy_out            = 1'b0;

    case (state)
      IDLE: begin
        count_next = 8'd0;
        if (instr_req && data_req) begin
          if (last_grant) begin
            state_next      = GRANT_INSTR;
            last_grant_next = 1'b0;
          end else begin
            state_next      = GRANT_DATA;
            last_grant_next = 1'b1;
          end
        end else if (instr_req) begin
          state_next      = GRANT_INSTR;
          last_grant_next = 1'b0;
        end else if (data_req) begin
          state_next      = GRANT_DATA;
          last_grant_next = 1'b1;
        end
      end

      GRANT_INSTR: begin
        busy_out        = 1'b1;
        bus_address_out = instr_address_in;
        if (!instr_req) begin
          state_next = IDLE;
        end else begin
          bus_read_out = !timed_out;
          if (bus_ready_in) begin
            instr_ready_out = 1'b1;
            state_next      = IDLE;
          end else if (timed_out) begin
            instr_ready_out = 1'b1;
            instr_fault_out = 1'b1;
            state_next      = IDLE;
          end else begin
            count_next = count + 8'd1;
          end
        end
      end

      GRANT_DATA: begin
        busy_out            = 1'b1;
        bus_address_out     = data_address_in;
        bus_write_mask_out  = data_write_mask_in;
        bus_write_value_out = data_write_value_in;
        if (!data_req) begin
          state_next = IDLE;
        end else begin
          bus_write_out = data_write_in & !timed_out;
          bus_read_out  = data_read_in & !data_write_in & !timed_out;
          if (bus_ready_in) begin
            data_ready_out = 1'b1;
            state_next     = IDLE;
          end else if (timed_out) begin
            data_ready_out = 1'b1;
            data_fault_out = 1'b1;
            state_next     = IDLE;
          end else begin
            count_next = count + 8'd1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Reset abandons whatever is in flight: nothing leaves the arbiter this
    // cycle, and the register block returns everything to IDLE at the edge.
    if (reset) begin
      instr_ready_out     = 1'b0;
      instr_fault_out     = 1'b0;
      data_ready_out      = 1'b0;
      data_fault_out      = 1'b0;
      bus_address_out     = 32'd0;
      bus_read_out        = 1'b0;
      bus_write_out       = 1'b0;
      bus_write_mask_out  = 4'd0;
      bus_write_value_out = 32'd0;
      busy_out            = 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// tb_rv32_bus_arbiter
// -------------------
// Directed bench for rv32_bus_arbiter built with TIMEOUT_CYCLES = 4.
// Inputs change 1 ns after each rising edge and outputs are sampled 1 ns later.
// ctl packs {busy, bus_read, bus_write, instr_ready, instr_fault,
// data_ready, data_fault} so one comparison covers the handshake state.
module tb_rv32_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] instr_address_in;
  logic        instr_read_in;
  logic [31:0] instr_read_value_out;
  logic        instr_ready_out;
  logic        instr_fault_out;
  logic [31:0] data_address_in;
  logic        data_read_in;
  logic        data_write_in;
  logic [3:0]  data_write_mask_in;
  logic [31:0] data_write_value_in;
  logic [31:0] data_read_value_out;
  logic        data_ready_out;
  logic        data_fault_out;
  logic [31:0] bus_address_out;
  logic        bus_read_out;
  logic        bus_write_out;
  logic [3:0]  bus_write_mask_out;
  logic [31:0] bus_write_value_out;
  logic [31:0] bus_read_value_in;
  logic        bus_ready_in;
  logic        busy_out;

  logic [6:0]  ctl;
  int          checks;
  int          fails;

  assign ctl = {busy_out, bus_read_out, bus_write_out, instr_ready_out,
                instr_fault_out, data_ready_out, data_fault_out};

  rv32_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk                  (clk),
    .reset                (reset),
    .instr_address_in     (instr_address_in),
    .instr_read_in        (instr_read_in),
    .instr_read_value_out (instr_read_value_out),
    .instr_ready_out      (instr_ready_out),
    .instr_fault_out      (instr_fault_out),
    .data_address_in      (data_address_in),
    .data_read_in         (data_read_in),
    .data_write_in        (data_write_in),
    .data_write_mask_in   (data_write_mask_in),
    .data_write_value_in  (data_write_value_in),
    .data_read_value_out  (data_read_value_out),
    .data_ready_out       (data_ready_out),
    .data_fault_out       (data_fault_out),
    .bus_address_out      (bus_address_out),
    .bus_read_out         (bus_read_out),
    .bus_write_out        (bus_write_out),
    .bus_write_mask_out   (bus_write_mask_out),
    .bus_write_value_out  (bus_write_value_out),
    .bus_read_value_in    (bus_read_value_in),
    .bus_ready_in         (bus_ready_in),
    .busy_out             (busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_read_in = 1'b0;
    data_read_in  = 1'b0;
    data_write_in = 1'b0;
    bus_ready_in  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instr_read_in = 1'b1;
    data_read_in  = 1'b1;
    bus_ready_in  = 1'b1;
    tick();
    tick();
    checks++;
    if (ctl !== 7'b0000000) begin
      fails++;
      $display("[TB] FAIL reset_hold: ctl got %b expected %b", ctl, 7'b0000000);
    end
    reset = 1'b0;
    idle_inputs();
    tick();
    checks++;
    if (ctl !== 7'b0000000) begin
      fails++;
      $display("[TB] FAIL reset_release: ctl got %b expected %b", ctl, 7'b0000000);
    end
  endtask

  task automatic test_idle_ready();
    bus_ready_in = 1'b1;
    #1;
    checks++;
    if (ctl !== 7'b0000000) begin
      fails++;
      $display("[TB] FAIL idle_ready: ctl got %b expected %b", ctl, 7'b0000000);
    end
    tick();
    checks++;
    if (ctl !== 7'b0000000) begin
      fails++;
      $display("[TB] FAIL idle_ready_next: ctl got %b expected %b", ctl, 7'b0000000);
    end
    bus_ready_in = 1'b0;
  endtask

  task automatic test_lone_fetch();
    instr_address_in = 32'h0000_0100;
    instr_read_in    = 1'b1;
    #1;
    checks++;
    if (ctl !== 7'b0000000) begin
      fails++;
      $display("[TB] FAIL fetch_cycle0: ctl got %b expected %b", ctl, 7'b0000000);
    end
    tick();
    checks++;
    if (ctl !== 7'b1100000) begin
      fails++;
      $display("[TB] FAIL fetch_cycle1: ctl got %b expected %b", ctl, 7'b1100000);
    end
    checks++;
    if (bus_address_out !== 32'h0000_0100) begin
      fails++;
      $display("[TB] FAIL fetch_addr: got %h expected %h", bus_address_out, 32'h0000_0100);
    end
    bus_ready_in      = 1'b1;
    bus_read_value_in = 32'h0000_0013;
    #1;
    checks++;
    if (ctl !== 7'b1101000) begin
      fails++;
      $display("[TB] FAIL fetch_cycle2: ctl got %b expected %b", ctl, 7'b1101000);
    end
    checks++;
    if (instr_read_value_out !== 32'h0000_0013) begin
      fails++;
      $display("[TB] FAIL fetch_value: got %h expected %h", instr_read_value_out, 32'h0000_0013);
    end
    idle_inputs();
    tick();
    checks++;
    if (ctl !== 7'b0000000) begin
      fails++;
      $display("[TB] FAIL fetch_cycle3: ctl got %b expected %b", ctl, 7'b0000000);
    end
  endtask

  task automatic test_round_robin();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    instr_address_in = 32'h0000_0200;
    data_address_in  = 32'h3000_0000;
    instr_read_in    = 1'b1;
    data_read_in     = 1'b1;
    bus_ready_in     = 1'b1;
    tick();
    checks++;
    if (ctl !== 7'b1101000 || bus_address_out !== 32'h0000_0200) begin
      fails++;
      $display("[TB] FAIL tie_first: ctl/addr got %b/%h expected %b/%h",
               ctl, bus_address_out, 7'b1101000, 32'h0000_0200);
    end
    tick();
    checks++;
    if (ctl !== 7'b0000000) begin
      fails++;
      $display("[TB] FAIL tie_bubble: ctl got %b expected %b", ctl, 7'b0000000);
    end
    tick();
    checks++;
    if (ctl !== 7'b1100010 || bus_address_out !== 32'h3000_0000) begin
      fails++;
      $display("[TB] FAIL tie_second: ctl/addr got %b/%h expected %b/%h",
               ctl, bus_address_out, 7'b1100010, 32'h3000_0000);
    end
    tick();
    tick();
    checks++;
    if (ctl !== 7'b1101000 || bus_address_out !== 32'h0000_0200) begin
      fails++;
      $display("[TB] FAIL tie_third: ctl/addr got %b/%h expected %b/%h",
               ctl, bus_address_out, 7'b1101000, 32'h0000_0200);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_data_write();
    data_address_in     = 32'h2000_0004;
    data_write_mask_in  = 4'b0011;
    data_write_value_in = 32'hDEAD_BEEF;
    data_read_in        = 1'b1;
    data_write_in       = 1'b1;
    tick();
    checks++;
    if (ctl !== 7'b1010000) begin
      fails++;
      $display("[TB] FAIL write_ctl: ctl got %b expected %b", ctl, 7'b1010000);
    end
    checks++;
    if ({bus_address_out, bus_write_mask_out, bus_write_value_out} !==
        {32'h2000_0004, 4'b0011, 32'hDEAD_BEEF}) begin
      fails++;
      $display("[TB] FAIL write_bus: addr/mask/value got %h/%b/%h expected 20000004/0011/deadbeef",
               bus_address_out, bus_write_mask_out, bus_write_value_out);
    end
    bus_ready_in = 1'b1;
    #1;
    checks++;
    if (ctl !== 7'b1010010) begin
      fails++;
      $display("[TB] FAIL write_ready: ctl got %b expected %b", ctl, 7'b1010010);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    instr_address_in = 32'h0000_0400;
    instr_read_in    = 1'b1;
    tick();
    checks++;
    if (ctl !== 7'b1100000) begin
      fails++;
      $display("[TB] FAIL timeout_c1: ctl got %b expected %b", ctl, 7'b1100000);
    end
    tick();
    tick();
    checks++;
    if (ctl !== 7'b1100000) begin
      fails++;
      $display("[TB] FAIL timeout_c3: ctl got %b expected %b", ctl, 7'b1100000);
    end
    tick();
    checks++;
    if (ctl !== 7'b1001100) begin
      fails++;
      $display("[TB] FAIL timeout_c4: ctl got %b expected %b", ctl, 7'b1001100);
    end
    instr_read_in = 1'b0;
    tick();
    checks++;
    if (ctl !== 7'b0000000) begin
      fails++;
      $display("[TB] FAIL timeout_idle: ctl got %b expected %b", ctl, 7'b0000000);
    end
  endtask

  task automatic test_timeout_ready();
    instr_read_in = 1'b1;
    tick();
    tick();
    tick();
    tick();
    bus_ready_in = 1'b1;
    #1;
    checks++;
    if (ctl !== 7'b1101000) begin
      fails++;
      $display("[TB] FAIL timeout_ready: ctl got %b expected %b", ctl, 7'b1101000);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_abort();
    data_address_in = 32'h4000_0000;
    data_read_in    = 1'b1;
    tick();
    checks++;
    if (ctl !== 7'b1100000) begin
      fails++;
      $display("[TB] FAIL abort_c1: ctl got %b expected %b", ctl, 7'b1100000);
    end
    tick();
    data_read_in = 1'b0;
    #1;
    checks++;
    if (ctl !== 7'b1000000) begin
      fails++;
      $display("[TB] FAIL abort_c2: ctl got %b expected %b", ctl, 7'b1000000);
    end
    tick();
    checks++;
    if (ctl !== 7'b0000000) begin
      fails++;
      $display("[TB] FAIL abort_idle: ctl got %b expected %b", ctl, 7'b0000000);
    end
    // Same again, with reset cutting the grant short.
    data_read_in = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (ctl !== 7'b0000000 || bus_address_out !== 32'd0) begin
      fails++;
      $display("[TB] FAIL reset_mid_grant: ctl/addr got %b/%h expected %b/%h",
               ctl, bus_address_out, 7'b0000000, 32'd0);
    end
    tick();
    reset = 1'b0;
    instr_address_in = 32'h0000_0500;
    instr_read_in    = 1'b1;
    bus_ready_in     = 1'b1;
    #1;
    checks++;
    if (ctl !== 7'b0000000) begin
      fails++;
      $display("[TB] FAIL reset_idle: ctl got %b expected %b", ctl, 7'b0000000);
    end
    tick();
    checks++;
    if (ctl !== 7'b1101000 || bus_address_out !== 32'h0000_0500) begin
      fails++;
      $display("[TB] FAIL reset_tie: ctl/addr got %b/%h expected %b/%h",
               ctl, bus_address_out, 7'b1101000, 32'h0000_0500);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    checks              = 0;
    fails               = 0;
    reset               = 1'b0;
    instr_address_in    = 32'd0;
    data_address_in     = 32'd0;
    data_write_mask_in  = 4'd0;
    data_write_value_in = 32'd0;
    bus_read_value_in   = 32'd0;
    idle_inputs();
    test_reset();
    test_idle_ready();
    test_lone_fetch();
    test_round_robin();
    test_data_write();
    test_timeout();
    test_timeout_ready();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rv32_bus_arbiter.md
RV32_BUS_ARBITER -- requirements
Module: rv32_bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max bus cycles per grant before fault; range 1..255, 8-bit counter.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 instr_address_in  in  32  fetch address; instr_read_in  in  1  fetch request.
REQ-005 instr_read_value_out  out  32  fetched word; instr_ready_out  out  1  fetch complete; instr_fault_out  out  1  fetch timed out.
REQ-006 data_address_in  in  32; data_read_in  in  1; data_write_in  in  1; data_write_mask_in  in  4 byte enables; data_write_value_in  in  32.
REQ-007 data_read_value_out  out  32; data_ready_out  out  1; data_fault_out  out  1.
REQ-008 bus_address_out  out  32; bus_read_out  out  1; bus_write_out  out  1; bus_write_mask_out  out  4; bus_write_value_out  out  32.
REQ-009 bus_read_value_in  in  32; bus_ready_in  in  1  slave completes current access this cycle.
REQ-010 busy_out  out  1  high whenever state is not IDLE.

Function
REQ-011 FSM states: IDLE, GRANT_INSTR, GRANT_DATA; state and last_grant are registered.
REQ-012 Data request = data_read_in | data_write_in; instr request = instr_read_in.
REQ-013 IDLE, single requester: enter that requester's GRANT state next cycle.
REQ-014 IDLE, both requesting: grant requester not in last_grant (round-robin); last_grant updated on GRANT entry.
REQ-015 IDLE, no request: stay IDLE; all bus_* control outputs 0.
REQ-016 GRANT_X: bus_address/read/write/mask/value driven combinationally from requester X; other requester's inputs ignored.
REQ-017 GRANT_INSTR: bus_write_out = 0, bus_write_mask_out = 0.
REQ-018 GRANT_DATA, data_read_in and data_write_in both high: write wins, bus_read_out = 0.
REQ-019 In GRANT_X, bus_ready_in high: X_ready_out = 1 same cycle, X_read_value_out = bus_read_value_in; state -> IDLE next cycle.
REQ-020 Minimum latency: request sampled at edge N, bus access visible cycle N+1, completes earliest cycle N+1; one IDLE bubble between grants.
REQ-021 X_ready_out and X_fault_out are 0 outside GRANT_X; read_value outputs are don't-care when ready is 0.
REQ-022 Timeout counter cleared on GRANT entry, +1 each GRANT cycle with bus_ready_in low.
REQ-023 Counter reaching TIMEOUT_CYCLES with bus_ready_in low: X_ready_out = 1 and X_fault_out = 1 that cycle, bus_read/write_out forced 0, state -> IDLE.
REQ-024 bus_ready_in high on the timeout cycle: normal completion, no fault.
REQ-025 Requester drops request mid-grant: bus_read/write_out follow to 0 that cycle, no ready pulse, state -> IDLE next cycle (abort).
REQ-026 bus_ready_in high in IDLE: ignored, no ready pulse.
REQ-027 Requesters hold address/data stable until their ready; arbiter never registers requester data.

Reset
REQ-028 reset high at posedge: state = IDLE, last_grant = DATA (first tie goes to instr), counter = 0.
REQ-029 During and after reset: bus_read_out, bus_write_out, instr_ready_out, data_ready_out, faults, busy_out all 0.
REQ-030 reset mid-grant: access abandoned, no ready or fault pulse, state IDLE next cycle; bus outputs 0 from that cycle.

Verification
REQ-031 Lone fetch: instr_read_in=1, addr 0x0000_0100; bus_ready_in=1 with 0x0000_0013 on 2nd cycle -> bus_read_out at 0x100 from cycle 1, instr_ready_out=1 and value 0x13 on cycle 2, busy_out low cycle 3.
REQ-032 Tie after reset: both request in same cycle, bus ready immediately -> instr granted first, then data; next tie goes instr again (alternation).
REQ-033 Data write: addr 0x2000_0004, mask 4'b0011, value 0xDEAD_BEEF, read also high -> bus_write_out=1, bus_read_out=0, mask 0011, value DEADBEEF; data_ready_out on bus_ready_in.
REQ-034 Timeout: TIMEOUT_CYCLES=4, bus_ready_in held low -> instr_ready_out=1 and instr_fault_out=1 on 4th GRANT cycle, IDLE next cycle.
REQ-035 Abort/reset: data_read_in dropped on 2nd grant cycle -> no data_ready_out, IDLE next cycle; repeat with reset pulsed instead -> same, last_grant = DATA.
